// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: MEM stage (port 0) and debug/loader (port 1).
// Define DMEM_ARB_RR_EN for round-robin; otherwise fixed priority with a starvation counter.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    logic p1_wins_tie;

`ifdef DMEM_ARB_RR_EN
    logic last_gnt;

    // last_gnt = 1 means port 1 was served last, so port 0 takes the next tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= 1'b1;
        end else if (m0_gnt) begin
            last_gnt <= 1'b0;
        end else if (m1_gnt) begin
            last_gnt <= 1'b1;
        end
    end

    assign p1_wins_tie = ~last_gnt;
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= 4'd0;
        end else if (!m1_req || m1_gnt) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign p1_wins_tie = (starve_cnt == LIMIT);
`endif

    // Grants are gated by reset so nothing reaches memory while reset_n is low
    always_comb begin
        m0_gnt = reset_n & m0_req & (~m1_req | ~p1_wins_tie);
        m1_gnt = reset_n & m1_req & (~m0_req | p1_wins_tie);
    end

    always_comb begin
        mem_we = 1'b0;
        mem_a  = 32'd0;
        mem_wd = 32'd0;
        if (m0_gnt) begin
            mem_we = m0_we;
            mem_a  = m0_addr;
            mem_wd = m0_wdata;
        end else if (m1_gnt) begin
            mem_we = m1_we;
            mem_a  = m1_addr;
            mem_wd = m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= 32'd0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= 32'd0;
        end else begin
            m0_rvalid <= m0_gnt & ~m0_we;
            m1_rvalid <= m1_gnt & ~m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rdata <= mem_rd;
            end
            if (m1_gnt && !m1_we) begin
                m1_rdata <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table plus tie, reset and idle sequences.
// Tie expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [64] = '{default: 32'd0};
    logic [31:0] memSnap [64];

    int assertions = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Reference memory: combinational read, clocked write, word-indexed
    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    end
    assign mem_rd = mem[mem_a[7:2]];

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic        g0, g1, mwe;
        logic [31:0] ma, mwd;
        logic        rv0, rv1;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic doReset();
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic exp0, exp1;

        vecs[0] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b0, 32'h0,32'h0};
        vecs[1] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h0C,32'hDEADBEEF, 1'b0,1'b1,1'b1, 32'h0C,32'hDEADBEEF, 1'b0,1'b0, 32'h0,32'h0};
        vecs[2] = '{1'b1,1'b0,32'h0C,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0, 32'h0C,32'h0, 1'b1,1'b0, 32'hDEADBEEF,32'h0};
        vecs[3] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,1'b0, 32'h0,32'h0, 1'b0,1'b0, 32'hDEADBEEF,32'h0};
        vecs[4] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h0C,32'h55, 1'b0,1'b1,1'b0, 32'h0C,32'h55, 1'b0,1'b1, 32'hDEADBEEF,32'hDEADBEEF};
        vecs[5] = '{1'b1,1'b1,32'h10,32'h11, 1'b1,1'b1,32'h10,32'h22, 1'b1,1'b0,1'b1, 32'h10,32'h11, 1'b0,1'b0, 32'hDEADBEEF,32'hDEADBEEF};
        vecs[6] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h10,32'h22, 1'b0,1'b1,1'b1, 32'h10,32'h22, 1'b0,1'b0, 32'hDEADBEEF,32'hDEADBEEF};
        vecs[7] = '{1'b1,1'b0,32'h10,32'h0, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b0, 32'h10,32'h0, 1'b1,1'b0, 32'h22,32'hDEADBEEF};
        vecs[8] = '{1'b1,1'b1,32'h13,32'hA5A5, 1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,1'b1, 32'h13,32'hA5A5, 1'b0,1'b0, 32'h22,32'hDEADBEEF};
        vecs[9] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h12,32'h0, 1'b0,1'b1,1'b0, 32'h12,32'h0, 1'b0,1'b1, 32'h22,32'hA5A5};

        reset_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("reset m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        checkOutput("reset m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        checkOutput("reset m0_rdata", m0_rdata, 32'd0);
        checkOutput("reset m1_rdata", m1_rdata, 32'd0);
        doReset();

        // Table: inputs applied after negedge, comb outputs checked mid-cycle, registered ones after the edge
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                          vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            #1;
            checkOutput($sformatf("v%0d m0_gnt", i), {31'd0, m0_gnt}, {31'd0, vecs[i].g0});
            checkOutput($sformatf("v%0d m1_gnt", i), {31'd0, m1_gnt}, {31'd0, vecs[i].g1});
            checkOutput($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, vecs[i].mwe});
            checkOutput($sformatf("v%0d mem_a", i), mem_a, vecs[i].ma);
            checkOutput($sformatf("v%0d mem_wd", i), mem_wd, vecs[i].mwd);
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d m0_rvalid", i), {31'd0, m0_rvalid}, {31'd0, vecs[i].rv0});
            checkOutput($sformatf("v%0d m1_rvalid", i), {31'd0, m1_rvalid}, {31'd0, vecs[i].rv1});
            checkOutput($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].rd0);
            checkOutput($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].rd1);
            @(negedge clk);
        end

        // Continuous tie from reset: both ports read every cycle
        doReset();
        for (int i = 0; i < 10; i++) begin
`ifdef DMEM_ARB_RR_EN
            exp1 = (i % 2) == 1;
`else
            exp1 = (i % 5) == 4;
`endif
            exp0 = ~exp1;
            applyStimulus(1'b1, 1'b0, 32'h0C, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
            #1;
            checkOutput($sformatf("tie%0d m0_gnt", i), {31'd0, m0_gnt}, {31'd0, exp0});
            checkOutput($sformatf("tie%0d m1_gnt", i), {31'd0, m1_gnt}, {31'd0, exp1});
            @(posedge clk);
            #1;
            checkOutput($sformatf("tie%0d m0_rvalid", i), {31'd0, m0_rvalid}, {31'd0, exp0});
            checkOutput($sformatf("tie%0d m1_rvalid", i), {31'd0, m1_rvalid}, {31'd0, exp1});
            if (exp1) checkOutput($sformatf("tie%0d m1_rdata", i), m1_rdata, 32'hA5A5);
            @(negedge clk);
        end

        // Reset asserted in the cycle after a port 0 read grant
        applyStimulus(1'b1, 1'b0, 32'h0C, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rst pre m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h20, 32'h77, 1'b1, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("rst m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        checkOutput("rst m0_rdata", m0_rdata, 32'd0);
        checkOutput("rst m0_gnt", {31'd0, m0_gnt}, 32'd0);
        checkOutput("rst m1_gnt", {31'd0, m1_gnt}, 32'd0);
        checkOutput("rst mem_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("post-rst%0d m0_rvalid", i), {31'd0, m0_rvalid}, 32'd0);
        end
        checkOutput("post-rst mem[8]", mem[8], 32'd0);

        // Idle bus for 10 cycles: memory must stay untouched
        @(negedge clk);
        for (int w = 0; w < 64; w++) memSnap[w] = mem[w];
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("idle%0d gnt", i), {30'd0, m1_gnt, m0_gnt}, 32'd0);
            checkOutput($sformatf("idle%0d mem_we", i), {31'd0, mem_we}, 32'd0);
            checkOutput($sformatf("idle%0d mem_a", i), mem_a, 32'd0);
            checkOutput($sformatf("idle%0d mem_wd", i), mem_wd, 32'd0);
            @(negedge clk);
        end
        for (int w = 0; w < 64; w++) begin
            checkOutput($sformatf("idle mem[%0d]", w), mem[w], memSnap[w]);
        end
        checkOutput("final mem[3]", mem[3], 32'hDEADBEEF);
        checkOutput("final mem[4]", mem[4], 32'hA5A5);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory (64 words, combinational read, clocked write) between the pipeline MEM stage (port 0) and the debug/loader port (port 1). It issues at most one memory access per cycle, grants on a per-cycle request/grant handshake, and returns read data on a registered response one cycle after grant. It sits between the MEM stage and the data memory, and drives the memory's `we`, `a` and `wd` inputs.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied cycles of port 1 after which port 1 is force-granted. Fixed-priority mode only. Legal range 1..15.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `m0_req`, in, 1: port 0 access request.
- `m0_we`, in, 1: port 0 write enable (1 = write, 0 = read).
- `m0_addr`, in, 32: port 0 byte address; bits [1:0] are ignored.
- `m0_wdata`, in, 32: port 0 write data.
- `m0_gnt`, out, 1: port 0 access performed this cycle.
- `m0_rvalid`, out, 1: port 0 read response valid.
- `m0_rdata`, out, 32: port 0 read data.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as the port 0 signals, for port 1.
- `mem_we`, out, 1: memory write enable.
- `mem_a`, out, 32: memory byte address.
- `mem_wd`, out, 32: memory write data.
- `mem_rd`, in, 32: memory combinational read data.

## Operation
- **Arbitration** is combinational within the cycle.
  - Only one port requests: that port is granted.
  - Both ports request: the winner is chosen by the policy below.
  - Neither port requests: no grant.
- **Granted port's signals are muxed to memory:**
  - `mem_we` = granted port's `we`.
  - `mem_a` = granted port's `addr`.
  - `mem_wd` = granted port's `wdata`.
- **With no grant:** `mem_we` = 0, `mem_a` = 0, `mem_wd` = 0. The memory never sees a write without a grant.
- **Requester rule:** hold `req`, `we`, `addr` and `wdata` stable until the cycle in which `gnt` = 1. The requester may deassert `req` or present a new request in the next cycle.
- **Write:** takes effect at the clock edge that ends the grant cycle. It produces no `rvalid`.
- **Read:** `mem_rd` is registered at the end of the grant cycle into `mX_rdata`. `mX_rvalid` pulses high for exactly one cycle in the next cycle.
- **`mX_rdata` retention:** holds its last value until the next read response on that port.
- **Fixed-priority policy (default):**
  - Port 0 wins ties.
  - 4-bit `starve_cnt` increments each cycle in which `m1_req` = 1 and `m1_gnt` = 0, saturating at `STARVE_LIMIT`.
  - When `starve_cnt` == `STARVE_LIMIT`, port 1 wins the next tie.
  - `starve_cnt` clears in every cycle in which `m1_gnt` = 1, and in every cycle in which `m1_req` = 0.
- **Reset mid-operation:** any pending `rvalid` is dropped, and `starve_cnt` and the round-robin pointer are cleared. A write already clocked into memory is not undone.

## Timing
- **Grant latency:** 0 cycles; `gnt` is asserted in the same cycle as `req`.
- **Read latency:** `rvalid`/`rdata` appear 1 cycle after `gnt`.
- **Throughput:** one access per cycle. Back-to-back grants on the same port, or alternating ports, are allowed.
- **Reset values:** `m0_rvalid` = `m1_rvalid` = 0, `m0_rdata` = `m1_rdata` = 0, `starve_cnt` = 0, `last_gnt` = 1 (port 0 favoured first).
- **During reset:** `m0_gnt` = `m1_gnt` = 0 and `mem_we` = 0 while `reset_n` = 0.

## Configuration
- **`DMEM_ARB_RR_EN` defined:** round-robin arbitration.
  - 1-bit `last_gnt` register updates on every grant.
  - On a tie, the port that is not `last_gnt` wins.
  - `starve_cnt` and `STARVE_LIMIT` have no effect and are compiled out.
- **`DMEM_ARB_RR_EN` undefined:** fixed priority with the starvation counter, as described in Operation.

## Test plan
- **Single read:** reset, write mem[3] = 0xDEADBEEF via port 1 (`m1_we` = 1, addr 0x0C); next cycle port 0 reads addr 0x0C.
  - Required: `m0_gnt` = 1 in the same cycle; `m0_rvalid` = 1 with `m0_rdata` = 0xDEADBEEF one cycle later; `m1_rvalid` stays 0.
- **Tie, fixed priority:** both ports request reads continuously, STARVE_LIMIT = 4.
  - Required: port 0 is granted 4 cycles, then port 1 once, then the pattern repeats.
- **Tie, `DMEM_ARB_RR_EN`:** both ports request continuously.
  - Required: grants alternate 0, 1, 0, 1, starting with port 0 after reset.
- **Simultaneous write conflict:** port 0 writes 0x11 and port 1 writes 0x22 to addr 0x10, both held until granted.
  - Required: the two writes land in grant order; a final read of 0x10 returns the later grant's data (0x22 in fixed-priority mode).
- **Reset mid-read:** assert `reset_n` = 0 in the cycle after a port 0 read grant.
  - Required: `m0_rvalid` = 0 and `m0_rdata` = 0 immediately (asynchronous reset), with no response after reset is released.
- **Idle bus:** no requests for 10 cycles.
  - Required: `mem_we` = 0, `mem_a` = 0, `mem_wd` = 0, no `gnt`, and memory contents unchanged.
